// File: rtl/sw_event_counter_pkg.sv
// sw_event_counter_pkg: shared constants, auto-repeat state type and width helper.
package sw_event_counter_pkg;

    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DN    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {IDLE, WAIT_HOLD, REPEAT} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/sw_event_counter_key_edge.sv
// key_edge: 2-FF synchroniser, optional debouncer (DEBOUNCE_EN) and rising-edge pulse.
// A key already held when reset releases is ignored until it is seen low once.
module key_edge #(
    parameter int DEB_CYC = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic pulse
);

    logic       sync1, sync2, prev, armed;
    logic [1:0] warm;

    if (DEB_CYC < 1) begin : g_bad
        $error("key_edge: DEB_CYC must be >= 1");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
            warm  <= 2'b00;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            prev  <= level;
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & ~sync2 & ~level);
        end
    end

`ifdef DEBOUNCE_EN
    logic [31:0] cnt;
    logic        deb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb <= 1'b0;
            cnt <= '0;
        end else if (sync2 == deb) begin
            cnt <= '0;
        end else if (cnt == 32'(DEB_CYC - 1)) begin
            deb <= sync2;
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

    assign level = deb;
`else
    assign level = sync2;
`endif

    assign pulse = level & ~prev & armed;

endmodule

// File: rtl/sw_event_counter.sv
// sw_event_counter: switch-loaded up/down event counter with wrap/saturate, sticky
// overflow and held-key auto-repeat. Optional key debouncing via DEBOUNCE_EN.
module sw_event_counter
    import sw_event_counter_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int THRESH   = 3,
    parameter int HOLD_CYC = 50_000_000,
    parameter int RPT_CYC  = 5_000_000,
    parameter int DEB_CYC  = 500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             key_load,
    input  logic             key_step,
    input  logic             dir,
    input  logic             sat,
    input  logic             auto_en,
    output logic [WIDTH-1:0] rez,
    output logic [WIDTH-1:0] ledr,
    output logic             evt,
    output logic             ovf,
    output logic             at_zero,
    output logic             at_max
);

    localparam int PCW = clog2(WIDTH + 1);

    if (WIDTH < 2 || WIDTH > 32 || THRESH < 0 || THRESH >= WIDTH ||
        HOLD_CYC < 2 || RPT_CYC < 1 || DEB_CYC < 1) begin : g_bad
        $error("sw_event_counter: parameter out of range");
    end

    logic           load_p, step_p, step_lvl, unused_load_lvl;
    logic [PCW-1:0] pc;
    logic           run, tick, edge_hit;
    logic [31:0]    timer;
    state_t         state;

    key_edge #(.DEB_CYC(DEB_CYC)) u_load (
        .clk(clk), .reset(reset), .key(key_load), .level(unused_load_lvl), .pulse(load_p)
    );
    key_edge #(.DEB_CYC(DEB_CYC)) u_step (
        .clk(clk), .reset(reset), .key(key_step), .level(step_lvl), .pulse(step_p)
    );

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + PCW'(sw[i]);
    end

    assign evt     = pc > PCW'(THRESH);
    assign ledr    = rez;
    assign at_zero = rez == '0;
    assign at_max  = &rez;

    assign run  = step_lvl & auto_en;
    assign tick = (state == IDLE && step_p) ||
                  (state == WAIT_HOLD && run && timer == 32'(HOLD_CYC - 1)) ||
                  (state == REPEAT && run && timer == 32'(RPT_CYC - 1));
    assign edge_hit = (dir == DIR_DN) ? at_zero : at_max;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            rez   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (step_p) begin
                    timer <= '0;
                    state <= auto_en ? WAIT_HOLD : IDLE;
                end
                WAIT_HOLD: begin
                    state <= !run ? IDLE : tick ? REPEAT : WAIT_HOLD;
                    timer <= tick ? '0 : timer + 32'd1;
                end
                REPEAT: begin
                    state <= run ? REPEAT : IDLE;
                    timer <= tick ? '0 : timer + 32'd1;
                end
                default: state <= IDLE;
            endcase
            // load outranks any step arriving in the same cycle
            if (load_p) begin
                rez <= sw;
                ovf <= 1'b0;
            end else if (tick && evt) begin
                rez <= (edge_hit && sat == MODE_SAT) ? rez : (dir == DIR_DN) ? rez - 1'b1 : rez + 1'b1;
                ovf <= ovf | edge_hit;
            end
        end
    end

endmodule
